// File: rtl/case_1_mul_share_arbiter.sv
// Round-robin scheduler sharing one combinational signed multiplier among N_REQ
// requesters; one operation in flight, result returned with the requester index.
module case_1_mul_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*din0_WIDTH-1:0] req_a,
  input  logic [N_REQ*din1_WIDTH-1:0] req_b,
  output logic [din0_WIDTH-1:0]       mul_din0,
  output logic [din1_WIDTH-1:0]       mul_din1,
  input  logic [dout_WIDTH-1:0]       mul_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [dout_WIDTH-1:0]       rsp_data,
  output logic [ID_WIDTH-1:0]         rsp_id
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t                        state_q, state_d;
  logic [ID_WIDTH-1:0]           rr_ptr_q, rr_ptr_d;
  logic signed [din0_WIDTH-1:0]  din0_q, din0_d;
  logic signed [din1_WIDTH-1:0]  din1_q, din1_d;
  logic [dout_WIDTH-1:0]         data_q, data_d;
  logic [ID_WIDTH-1:0]           id_q, id_d;
  logic                          vld_q, vld_d;

  logic                          found;
  logic [ID_WIDTH-1:0]           grant;
  logic [ID_WIDTH-1:0]           grant_next;

  // First valid requester at or after rr_ptr, wrapping within N_REQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_WIDTH'(idx);
      end
    end
  end

  assign grant_next = (grant == ID_WIDTH'(N_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    din0_d    = din0_q;
    din1_d    = din1_q;
    data_d    = data_q;
    id_d      = id_q;
    vld_d     = vld_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = N_REQ'(1) << grant;
          din0_d    = req_a[grant*din0_WIDTH +: din0_WIDTH];
          din1_d    = req_b[grant*din1_WIDTH +: din1_WIDTH];
          id_d      = grant;
          rr_ptr_d  = grant_next;
          state_d   = MUL;
        end
      end
      MUL: begin
        data_d  = mul_dout;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing is accepted while reset is held, even though state reads IDLE.
    if (ap_rst) req_ready = '0;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      din0_q   <= '0;
      din1_q   <= '0;
      data_q   <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      data_q   <= data_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
    end
  end

  assign mul_din0  = din0_q;
  assign mul_din1  = din1_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule
